// File: rtl/mul_div_if.sv
// Handshake and HI/LO bus between the execute-stage datapath and the
// iterative multiply/divide unit.
interface mul_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, opA, opB, hiWe, loWe, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, opA, opB, hiWe, loWe, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU, one bit per cycle, results into private HI/LO.
// Signed ops run on magnitudes; the sign is applied once in FIN.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mul_div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               isDiv;
  logic               negLo;   // negate product / quotient
  logic               negHi;   // negate remainder
  logic               divZero;
  logic [WIDTH-1:0]   b;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;     // {hi half, lo half}: product, or {remainder, quotient}

  logic               sgn;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divSh;
  logic [WIDTH+1:0]   divDiff;
  logic [2*WIDTH-1:0] mulNext, divNext, mulFix;

  // Operand magnitudes; abs(min_int) is naturally 2^(WIDTH-1) as unsigned
  always_comb begin
    sgn  = ~bus.op[0];
    absA = (sgn && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    absB = (sgn && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;
  end

  // One shift-add / restoring shift-subtract step and the final sign fix
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};
    divSh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divDiff = {1'b0, divSh} - {2'b00, b};
    // A borrow means the shifted remainder was below the divisor and fits in WIDTH bits
    if (!divDiff[WIDTH+1])
      divNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      divNext = {divSh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    mulFix  = negLo ? -acc : acc;
  end

  // Control FSM plus HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      isDiv    <= 1'b0;
      negLo    <= 1'b0;
      negHi    <= 1'b0;
      divZero  <= 1'b0;
      b        <= '0;
      acc      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            isDiv    <= bus.op[1];
            negLo    <= sgn & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            negHi    <= sgn & (bus.op[1] ? bus.opA[WIDTH-1]
                                         : (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]));
            divZero  <= bus.op[1] && (bus.opB == '0);
            b        <= bus.op[1] ? absB : absA;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? absA : absB)};
            cnt      <= CW'(WIDTH);
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            if (bus.hiWe) bus.hi <= bus.wdata;
            if (bus.loWe) bus.lo <= bus.wdata;
          end
        end
        CALC: begin
          acc <= isDiv ? divNext : mulNext;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          if (isDiv) begin
            bus.hi <= negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            bus.lo <= divZero ? '1 : (negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
          end else begin
            bus.hi <= mulFix[2*WIDTH-1:WIDTH];
            bus.lo <= mulFix[WIDTH-1:0];
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mul_div_unit;
  logic clk;
  logic reset;
  int   nCmp = 0;
  int   nBad = 0;

  mul_div_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit integer arithmetic straight from the op definitions
  function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb,
                                   output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
    case (o)
      2'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, bb}; eh = p[63:32]; el = p[31:0]; end
      2'd2: if (bb == 0) begin eh = a; el = '1; end
            else begin q = sa / sb; r = sa % sb; eh = 32'(r); el = 32'(q); end
      default: if (bb == 0) begin eh = a; el = '1; end
               else begin eh = a % bb; el = a / bb; end
    endcase
  endfunction

  // Drive one operation; return result, done latency and whether busy held
  task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb,
                      output logic [31:0] gh, output logic [31:0] gl,
                      output int lat, output bit busyOk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.opA = a; bus.opB = bb;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.opA = $urandom; bus.opB = $urandom;
    lat = -1;
    busyOk = bus.busy;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
      if (!bus.busy) busyOk = 1'b0;
    end
    gh = bus.hi;
    gl = bus.lo;
  endtask

  task automatic mtWrite(input logic weH, input logic weL, input logic [31:0] d);
    @(negedge clk);
    bus.hiWe = weH; bus.loWe = weL; bus.wdata = d;
    @(posedge clk); #1;
    bus.hiWe = 1'b0; bus.loWe = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    nCmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      nBad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu_max;
    logic [31:0] gh, gl;
    int lat; bit bOk;
    doOp(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, gh, gl, lat, bOk);
    nCmp++;
    if (gh !== 32'hFFFFFFFE || gl !== 32'h00000001) begin
      nBad++; $display("FAIL multu_max: hi=%h lo=%h, required fffffffe 00000001", gh, gl);
    end
    nCmp++;
    if (lat !== 33) begin nBad++; $display("FAIL multu_latency: %0d cycles, required 33", lat); end
    nCmp++;
    if (!bOk) begin nBad++; $display("FAIL multu_busy: busy dropped during operation"); end
    @(posedge clk); #1;
    nCmp++;
    if (bus.done !== 1'b0) begin nBad++; $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.done); end
  endtask

  task automatic test_directed;
    logic [1:0]  ops [7] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] av  [7] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] bv  [7] = '{32'd7, 32'h80000000, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] eh  [7] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2, 32'd5, 32'd0, 32'hFFFFFFF9};
    logic [31:0] el  [7] = '{32'hFFFFFFEB, 32'h0, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] gh, gl;
    int lat; bit bOk;
    for (int i = 0; i < 7; i++) begin
      doOp(ops[i], av[i], bv[i], gh, gl, lat, bOk);
      nCmp++;
      if (gh !== eh[i] || gl !== el[i] || lat !== 33) begin
        nBad++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, required %h %h 33",
                 i, ops[i], av[i], bv[i], gh, gl, lat, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_mthi_mtlo;
    mtWrite(1'b1, 1'b0, 32'h11112222);
    mtWrite(1'b0, 1'b1, 32'h33334444);
    nCmp++;
    if (bus.hi !== 32'h11112222 || bus.lo !== 32'h33334444) begin
      nBad++; $display("FAIL mt_single: hi=%h lo=%h, required 11112222 33334444", bus.hi, bus.lo);
    end
    mtWrite(1'b1, 1'b1, 32'hA5A55A5A);
    nCmp++;
    if (bus.hi !== 32'hA5A55A5A || bus.lo !== 32'hA5A55A5A) begin
      nBad++; $display("FAIL mt_both: hi=%h lo=%h, required a5a55a5a a5a55a5a", bus.hi, bus.lo);
    end
    // hiWe alongside start is ignored; HI/LO hold during CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.opA = 32'd100; bus.opB = 32'd7;
    bus.hiWe = 1'b1; bus.loWe = 1'b1; bus.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hiWe = 1'b0; bus.loWe = 1'b0;
    for (int k = 0; k < 40 && !bus.done; k++) begin
      if (bus.hi !== 32'hA5A55A5A || bus.lo !== 32'hA5A55A5A) begin
        nCmp++; nBad++;
        $display("FAIL hold_calc: hi=%h lo=%h at cycle %0d, required a5a55a5a", bus.hi, bus.lo, k);
        break;
      end
      @(posedge clk); #1;
    end
    nCmp++;
    if (bus.done !== 1'b1 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      nBad++; $display("FAIL mt_with_start: done=%b hi=%h lo=%h, required 1 2 14", bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_busy_ignore;
    int nDone = 0, doneAt = -1;
    logic [31:0] h0, rh, rl;
    h0 = bus.hi;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.opA = 32'hFFFFFFFF; bus.opB = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rh = 'x; rl = 'x;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 11) begin bus.start = 1'b0; bus.hiWe = 1'b0; end
      if (bus.done) begin nDone++; doneAt = k; rh = bus.hi; rl = bus.lo; end
      if (k < 33 && bus.hi !== h0) begin
        nCmp++; nBad++; $display("FAIL busy_mthi: hi=%h at cycle %0d, required %h", bus.hi, k, h0);
      end
      if (k == 10) begin
        bus.start = 1'b1; bus.op = 2'd0; bus.opA = 32'd3; bus.opB = 32'd5;
        bus.hiWe = 1'b1; bus.wdata = 32'hCAFEF00D;
      end
    end
    nCmp++;
    if (nDone !== 1 || doneAt !== 33 || rh !== 32'hFFFFFFFE || rl !== 32'h1) begin
      nBad++;
      $display("FAIL busy_ignore: dones=%0d at=%0d hi=%h lo=%h, required 1 33 fffffffe 00000001", nDone, doneAt, rh, rl);
    end
    nCmp++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'hFFFFFFFE) begin
      nBad++; $display("FAIL busy_noqueue: busy=%b hi=%h, required 0 fffffffe", bus.busy, bus.hi);
    end
  endtask

  task automatic test_mid_reset;
    int nDone = 0;
    logic [31:0] gh, gl;
    int lat; bit bOk;
    mtWrite(1'b1, 1'b1, 32'h12345678);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.opA = 32'hFFFFFFF9; bus.opB = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < 16; k++) begin @(posedge clk); #1; end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    nCmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      nBad++;
      $display("FAIL mid_reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) nDone++;
    end
    nCmp++;
    if (nDone !== 0) begin nBad++; $display("FAIL reset_abort: %0d cycles of busy/done after reset, required 0", nDone); end
    doOp(2'd3, 32'd100, 32'd7, gh, gl, lat, bOk);
    nCmp++;
    if (gh !== 32'd2 || gl !== 32'd14 || lat !== 33) begin
      nBad++; $display("FAIL after_reset: hi=%h lo=%h lat=%0d, required 2 14 33", gh, gl, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, bb, gh, gl, eh, el;
    logic [1:0] o;
    int lat; bit bOk;
    for (int i = 0; i < 60; i++) begin
      o  = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      bb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if (o[1] && $urandom_range(0, 2) == 0) bb = 32'($urandom_range(1, 300));
      refModel(o, a, bb, eh, el);
      doOp(o, a, bb, gh, gl, lat, bOk);
      nCmp++;
      if (gh !== eh || gl !== el || lat !== 33 || !bOk) begin
        nBad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d busy=%b, required %h %h 33 1",
                 i, o, a, bb, gh, gl, lat, bOk, eh, el);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.opA = '0; bus.opB = '0;
    bus.hiWe = 1'b0; bus.loWe = 1'b0; bus.wdata = '0;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    test_multu_max();
    test_directed();
    test_mthi_mtlo();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
